// File: rtl/mips_pkg.sv
// Shared fetch-path constants and the fetch sequencer state type.
package mips_pkg;

    localparam int PC_W       = 32;
    localparam int RESET_PC   = 0;
    localparam int IMEM_DEPTH = 256;
    localparam int JUMP_W     = 26;
    localparam int BR_IMM_W   = 16;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC mux: jump beats branch beats sequential, all modulo 2^PC_W.
module pc_next_calc #(
    parameter int PC_W = mips_pkg::PC_W
) (
    input  logic [PC_W-1:0]               pc,
    input  logic                          branch_take,
    input  logic [mips_pkg::BR_IMM_W-1:0] branch_imm,
    input  logic                          jump_take,
    input  logic [mips_pkg::JUMP_W-1:0]   jump_target,
    output logic [PC_W-1:0]               pc_plus1,
    output logic [PC_W-1:0]               next_pc,
    output logic                          redir_vld
);
    import mips_pkg::*;

    logic [PC_W-1:0] br_off_s;
    logic [PC_W-1:0] br_tgt_s;
    logic [PC_W-1:0] jmp_tgt_s;

    assign pc_plus1  = pc + PC_W'(1);
    assign br_off_s  = {{(PC_W-BR_IMM_W){branch_imm[BR_IMM_W-1]}}, branch_imm};
    assign br_tgt_s  = pc_plus1 + br_off_s;
    // Jump keeps the upper bits of the sequential PC, MIPS-style region jump.
    assign jmp_tgt_s = {pc_plus1[PC_W-1:JUMP_W], jump_target};
    assign redir_vld = jump_take | branch_take;

    // Select the target by redirect priority.
    always_comb begin
        next_pc = pc_plus1;
        if (jump_take) begin
            next_pc = jmp_tgt_s;
        end else if (branch_take) begin
            next_pc = br_tgt_s;
        end else begin
            next_pc = pc_plus1;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencer feeding instruct_mem: BOOT/RUN/HOLD/HALT FSM,
// pending-redirect capture across stalls and a sticky out-of-range fault.
module pc_fetch_unit #(
    parameter int PC_W       = mips_pkg::PC_W,
    parameter int RESET_PC   = mips_pkg::RESET_PC,
    parameter int IMEM_DEPTH = mips_pkg::IMEM_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic                          branch_take,
    input  logic [mips_pkg::BR_IMM_W-1:0] branch_imm,
    input  logic                          jump_take,
    input  logic [mips_pkg::JUMP_W-1:0]   jump_target,
    input  logic                          halt_req,
    output logic [PC_W-1:0]               pc,
    output logic [PC_W-1:0]               pc_plus1,
    output logic                          fetch_valid,
    output logic                          fault,
    output logic [1:0]                    state_dbg
);
    import mips_pkg::*;

    localparam logic [PC_W-1:0] DEPTH_LIM = PC_W'(IMEM_DEPTH);
    localparam logic [PC_W-1:0] PC_INIT   = PC_W'(RESET_PC);

    fetch_state_t    state_r, state_s;
    logic [PC_W-1:0] pc_r, pc_s;
    logic [PC_W-1:0] pend_pc_r, pend_pc_s;
    logic            pend_vld_r, pend_vld_s;
    logic            fault_r, fault_s;
    logic            fetch_valid_r, fetch_valid_s;
    logic [PC_W-1:0] calc_pc_s;
    logic            redir_vld_s;
    logic            pc_upd_s;
    logic [PC_W-1:0] pc_cand_s;

    pc_next_calc #(.PC_W(PC_W)) u_next (
        .pc          (pc_r),
        .branch_take (branch_take),
        .branch_imm  (branch_imm),
        .jump_take   (jump_take),
        .jump_target (jump_target),
        .pc_plus1    (pc_plus1),
        .next_pc     (calc_pc_s),
        .redir_vld   (redir_vld_s)
    );

    // Next-state, next-PC, pending-redirect and fault resolution.
    always_comb begin
        state_s    = state_r;
        pend_vld_s = pend_vld_r;
        pend_pc_s  = pend_pc_r;
        fault_s    = fault_r;
        pc_upd_s   = 1'b0;
        pc_cand_s  = pc_r;
        case (state_r)
            BOOT: begin
                state_s = RUN;
            end
            RUN: begin
                if (halt_req) begin
                    state_s = HALT;
                end else if (stall) begin
                    state_s = HOLD;
                    if (redir_vld_s) begin
                        pend_vld_s = 1'b1;
                        pend_pc_s  = calc_pc_s;
                    end else begin
                        pend_vld_s = pend_vld_r;
                    end
                end else begin
                    pc_upd_s  = 1'b1;
                    pc_cand_s = calc_pc_s;
                end
            end
            HOLD: begin
                if (halt_req) begin
                    state_s    = HALT;
                    pend_vld_s = 1'b0;
                end else begin
                    // A redirect seen in the release cycle still counts as the newest one.
                    if (redir_vld_s) begin
                        pend_vld_s = 1'b1;
                        pend_pc_s  = calc_pc_s;
                    end else begin
                        pend_vld_s = pend_vld_r;
                    end
                    if (!stall) begin
                        state_s    = RUN;
                        pc_upd_s   = pend_vld_s;
                        pc_cand_s  = pend_pc_s;
                        pend_vld_s = 1'b0;
                    end else begin
                        state_s = HOLD;
                    end
                end
            end
            HALT: begin
                state_s = HALT;
            end
            default: begin
                state_s    = BOOT;
                pend_vld_s = 1'b0;
            end
        endcase

        if (pc_upd_s && (pc_cand_s >= DEPTH_LIM)) begin
            fault_s    = 1'b1;
            state_s    = HALT;
            pend_vld_s = 1'b0;
        end else begin
            fault_s = fault_s;
        end

        if (pc_upd_s) begin
            pc_s = pc_cand_s;
        end else begin
            pc_s = pc_r;
        end

        fetch_valid_s = (state_s == RUN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= BOOT;
            pc_r          <= PC_INIT;
            pend_vld_r    <= 1'b0;
            pend_pc_r     <= PC_INIT;
            fault_r       <= 1'b0;
            fetch_valid_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            pend_vld_r    <= pend_vld_s;
            pend_pc_r     <= pend_pc_s;
            fault_r       <= fault_s;
            fetch_valid_r <= fetch_valid_s;
        end
    end

    assign pc          = pc_r;
    assign fetch_valid = fetch_valid_r;
    assign fault       = fault_r;
    assign state_dbg   = state_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a default-depth instance (A) and a depth-8 instance (B)
// share stimulus; expected snapshots are queued per cycle and checked by a negedge monitor.
module tb_pc_fetch_unit;

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    logic        clk = 1'b0;
    logic        rst, stall, branch_take, jump_take, halt_req;
    logic [15:0] branch_imm;
    logic [25:0] jump_target;

    logic [31:0] pc_a, pc_plus1_a, pc_b, pc_plus1_b;
    logic        fv_a, fault_a, fv_b, fault_b;
    logic [1:0]  st_a, st_b;

    always #5 clk = ~clk;

    pc_fetch_unit dut_a (
        .clk(clk), .rst(rst), .stall(stall), .branch_take(branch_take),
        .branch_imm(branch_imm), .jump_take(jump_take), .jump_target(jump_target),
        .halt_req(halt_req), .pc(pc_a), .pc_plus1(pc_plus1_a),
        .fetch_valid(fv_a), .fault(fault_a), .state_dbg(st_a)
    );

    pc_fetch_unit #(.IMEM_DEPTH(8)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .branch_take(branch_take),
        .branch_imm(branch_imm), .jump_take(jump_take), .jump_target(jump_target),
        .halt_req(halt_req), .pc(pc_b), .pc_plus1(pc_plus1_b),
        .fetch_valid(fv_b), .fault(fault_b), .state_dbg(st_b)
    );

    typedef struct {
        int          cyc;
        bit          sel;
        logic [31:0] pc;
        logic        fv;
        logic        fault;
        logic [1:0]  st;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation queued for the current cycle.
    always @(negedge clk) begin : mon
        exp_t        e;
        logic [31:0] apc, apc1;
        logic        afv, aflt;
        logic [1:0]  ast;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_checks++;
            if (e.sel) begin
                apc = pc_b; apc1 = pc_plus1_b; afv = fv_b; aflt = fault_b; ast = st_b;
            end else begin
                apc = pc_a; apc1 = pc_plus1_a; afv = fv_a; aflt = fault_a; ast = st_a;
            end
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: check for cycle %0d reached monitor at cycle %0d", e.tag, e.cyc, cyc);
            end else if (apc !== e.pc || apc1 !== e.pc + 32'd1 || afv !== e.fv ||
                         aflt !== e.fault || ast !== e.st) begin
                n_fail++;
                $display("FAIL %s (dut %s): got pc=%0d pc_plus1=%0d fv=%0b fault=%0b st=%0d, want pc=%0d pc_plus1=%0d fv=%0b fault=%0b st=%0d",
                         e.tag, e.sel ? "B" : "A", apc, apc1, afv, aflt, ast,
                         e.pc, e.pc + 32'd1, e.fv, e.fault, e.st);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_dut(input bit sel, input logic [31:0] epc, input logic efv,
                              input logic eflt, input logic [1:0] est, input string tag);
        exp_t e;
        e.cyc = cyc; e.sel = sel; e.pc = epc; e.fv = efv;
        e.fault = eflt; e.st = est; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic expect_both(input logic [31:0] epc, input logic efv,
                               input logic [1:0] est, input string tag);
        expect_dut(1'b0, epc, efv, 1'b0, est, tag);
        expect_dut(1'b1, epc, efv, 1'b0, est, tag);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch_take = 1'b0; jump_take = 1'b0; halt_req = 1'b0;
        branch_imm = 16'd0; jump_target = 26'd0;

        // 1. reset, BOOT, then sequential fetch of words 0..3
        step(); expect_both(32'd0, 1'b0, S_BOOT, "reset");
        step(); expect_both(32'd0, 1'b0, S_BOOT, "reset_hold");
        rst = 1'b0;
        step(); expect_both(32'd0, 1'b1, S_RUN, "first_run");
        for (int i = 1; i <= 3; i++) begin
            step(); expect_both(32'(i), 1'b1, S_RUN, "seq");
        end

        // 2. forward branch from pc=3 (B faults at 9), jump back to 3, backward branch to 0
        branch_take = 1'b1; branch_imm = 16'd5;
        step();
        expect_dut(1'b0, 32'd9, 1'b1, 1'b0, S_RUN, "br_fwd");
        expect_dut(1'b1, 32'd9, 1'b0, 1'b1, S_HALT, "br_fault");
        branch_take = 1'b0;
        jump_take = 1'b1; jump_target = 26'd3;
        step();
        expect_dut(1'b0, 32'd3, 1'b1, 1'b0, S_RUN, "jmp_to_3");
        expect_dut(1'b1, 32'd9, 1'b0, 1'b1, S_HALT, "fault_frozen");
        jump_take = 1'b0;
        branch_take = 1'b1; branch_imm = 16'hFFFC;
        step();
        expect_dut(1'b0, 32'd0, 1'b1, 1'b0, S_RUN, "br_back");
        expect_dut(1'b1, 32'd9, 1'b0, 1'b1, S_HALT, "fault_frozen2");
        branch_take = 1'b0;

        // 3. jump and branch together at pc=4: jump wins
        for (int i = 1; i <= 4; i++) begin
            step(); expect_dut(1'b0, 32'(i), 1'b1, 1'b0, S_RUN, "seq2");
        end
        jump_take = 1'b1; jump_target = 26'd40; branch_take = 1'b1; branch_imm = 16'd5;
        step(); expect_dut(1'b0, 32'd40, 1'b1, 1'b0, S_RUN, "jmp_beats_br");
        branch_take = 1'b0;

        // 4. stall 3 cycles at pc=7 with a branch pended in the first one
        jump_target = 26'd7;
        step(); expect_dut(1'b0, 32'd7, 1'b1, 1'b0, S_RUN, "jmp_to_7");
        jump_take = 1'b0;
        stall = 1'b1; branch_take = 1'b1; branch_imm = 16'd2;
        step(); expect_dut(1'b0, 32'd7, 1'b0, 1'b0, S_HOLD, "stall1");
        branch_take = 1'b0;
        step(); expect_dut(1'b0, 32'd7, 1'b0, 1'b0, S_HOLD, "stall2");
        step(); expect_dut(1'b0, 32'd7, 1'b0, 1'b0, S_HOLD, "stall3");
        stall = 1'b0;
        step(); expect_dut(1'b0, 32'd10, 1'b1, 1'b0, S_RUN, "stall_release");
        stall = 1'b1;
        step(); expect_dut(1'b0, 32'd10, 1'b0, 1'b0, S_HOLD, "stall_plain");
        stall = 1'b0;
        step(); expect_dut(1'b0, 32'd10, 1'b1, 1'b0, S_RUN, "refetch_no_pend");
        step(); expect_dut(1'b0, 32'd11, 1'b1, 1'b0, S_RUN, "seq_after_stall");

        // 5. sequential run past depth 8 on B, then reset clears the fault
        rst = 1'b1;
        step(); expect_both(32'd0, 1'b0, S_BOOT, "reset2");
        rst = 1'b0;
        step(); expect_both(32'd0, 1'b1, S_RUN, "run2");
        for (int i = 1; i <= 7; i++) begin
            step(); expect_both(32'(i), 1'b1, S_RUN, "seq3");
        end
        step();
        expect_dut(1'b1, 32'd8, 1'b0, 1'b1, S_HALT, "depth_fault");
        expect_dut(1'b0, 32'd8, 1'b1, 1'b0, S_RUN, "no_fault_256");
        step();
        expect_dut(1'b1, 32'd8, 1'b0, 1'b1, S_HALT, "depth_fault_frozen");
        expect_dut(1'b0, 32'd9, 1'b1, 1'b0, S_RUN, "seq4");
        rst = 1'b1;
        step(); expect_both(32'd0, 1'b0, S_BOOT, "fault_clear");

        // 6. halt at pc=5; redirects and stall ignored until reset
        rst = 1'b0;
        step(); expect_both(32'd0, 1'b1, S_RUN, "run3");
        for (int i = 1; i <= 5; i++) begin
            step(); expect_both(32'(i), 1'b1, S_RUN, "seq5");
        end
        halt_req = 1'b1;
        step(); expect_both(32'd5, 1'b0, S_HALT, "halt");
        halt_req = 1'b0;
        jump_take = 1'b1; jump_target = 26'd20; branch_take = 1'b1; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); expect_both(32'd5, 1'b0, S_HALT, "halt_sticky");
        end
        jump_take = 1'b0; branch_take = 1'b0; stall = 1'b0;
        rst = 1'b1;
        step(); expect_both(32'd0, 1'b0, S_BOOT, "halt_reset");
        rst = 1'b0;

        step();
        step();
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
